// File: rtl/dfe_pkg.sv
// Shared DFE filter-array definitions: CIC geometry, Q1.15 limits, dec_sel type.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dfe_pkg;

    localparam int CIC_N_STAGES     = 5;
    localparam int CIC_MAX_DEC_LOG2 = 4;

    // Q1.15 saturation limits
    localparam int Q15_MAX = 32767;
    localparam int Q15_MIN = -32768;

    typedef logic [2:0] dec_sel_t;

    // Register width that holds the full R^N growth without loss
    function automatic int cic_acc_width(input int data_width, input int n_stages,
                                         input int max_dec_log2);
        return data_width + n_stages * max_dec_log2;
    endfunction

    // Requests beyond the largest supported ratio fall back to that ratio
    function automatic dec_sel_t clamp_dec_sel(input dec_sel_t d, input int max_log2);
        if (int'(d) > max_log2) begin
            return dec_sel_t'(max_log2);
        end
        return d;
    endfunction

endpackage

// File: rtl/cic_round_sat.sv
// CIC gain normalisation: runtime arithmetic right shift by N*log2(R), round-half-up, saturate.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumer qualifies the result.
//
// Ports:
//   acc_i  comb chain result (ACC_WIDTH, signed)
//   dec_i  active log2(R), already clamped
//   dat_o  normalised sample (DATA_WIDTH, signed)
//   ovf_o  result clipped to POS_LIM
//   unf_o  result clipped to NEG_LIM
module cic_round_sat
    import dfe_pkg::*;
#(
    parameter int ACC_WIDTH  = 36,
    parameter int DATA_WIDTH = 16,
    parameter int N_STAGES   = 5,
    parameter int POS_LIM    = Q15_MAX,
    parameter int NEG_LIM    = Q15_MIN
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_i,
    input  logic        [2:0]            dec_i,
    output logic signed [DATA_WIDTH-1:0] dat_o,
    output logic                         ovf_o,
    output logic                         unf_o
);

    // One guard bit so adding the rounding half can never wrap
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] POS_W = SW'(POS_LIM);
    localparam logic signed [SW-1:0] NEG_W = SW'(NEG_LIM);

    logic        [5:0]    shamt;
    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] half;
    logic signed [SW-1:0] rnd;
    logic signed [SW-1:0] shifted;

    always_comb begin
        shamt   = 6'(N_STAGES) * 6'(dec_i);
        ext     = SW'(acc_i);
        half    = '0;
        if (shamt != 6'd0) begin
            half = SW'(1) << (shamt - 6'd1);
        end
        rnd     = ext + half;
        shifted = rnd >>> shamt;

        dat_o = shifted[DATA_WIDTH-1:0];
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (shifted > POS_W) begin
            dat_o = POS_W[DATA_WIDTH-1:0];
            ovf_o = 1'b1;
        end else if (shifted < NEG_W) begin
            dat_o = NEG_W[DATA_WIDTH-1:0];
            unf_o = 1'b1;
        end
    end

endmodule

// File: rtl/cic_decimator.sv
// Hogenauer CIC decimator, R = 2^dec_sel (1..16), N integrators + N combs, Q1.15 in/out.
// Latency: 1 clk from the strobing valid_in to valid_out (plus N samples of filter delay).
// Backpressure: none; input qualified by valid_in, gaps hold all state.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_in, cic_in   input sample strobe and signed Q1.15 sample
//   dec_sel, cfg_load  requested log2(R); pulse latches it and flushes the datapath
//   bypass             registered pass-through, filter state frozen
//   cic_out, valid_out decimated sample and its one-cycle strobe
//   overflow/underflow saturation flags, qualified by valid_out
module cic_decimator
    import dfe_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_FRAC    = 15,
    parameter int N_STAGES     = CIC_N_STAGES,
    parameter int MAX_DEC_LOG2 = CIC_MAX_DEC_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] cic_in,
    input  logic [2:0]            dec_sel,
    input  logic                  cfg_load,
    input  logic                  bypass,
    output logic [DATA_WIDTH-1:0] cic_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ACC_WIDTH = cic_acc_width(DATA_WIDTH, N_STAGES, MAX_DEC_LOG2);
    localparam int PH_W      = MAX_DEC_LOG2;

    logic signed [ACC_WIDTH-1:0] int_q [N_STAGES];
    logic signed [ACC_WIDTH-1:0] int_d [N_STAGES];
    logic signed [ACC_WIDTH-1:0] dly_q [N_STAGES];
    logic signed [ACC_WIDTH-1:0] dly_d [N_STAGES];
    logic signed [ACC_WIDTH-1:0] comb_c [N_STAGES+1];

    logic [PH_W-1:0] phase_q, phase_d;
    logic [PH_W-1:0] phase_last;
    dec_sel_t        dec_q, dec_d;

    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  vld_q, vld_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                         run;
    logic                         dec_strobe;
    logic signed [ACC_WIDTH-1:0]  in_ext;
    logic signed [DATA_WIDTH-1:0] rs_dat;
    logic                         rs_ovf;
    logic                         rs_unf;

    assign phase_last = PH_W'((32'd1 << dec_q) - 32'd1);
    assign in_ext     = {{(ACC_WIDTH-DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};

    // A sample is consumed only when not frozen by bypass and not dropped by cfg_load
    assign run        = valid_in && !bypass && !cfg_load;
    assign dec_strobe = run && (phase_q == phase_last);

    // Comb chain at the decimated rate, differential delay 1, fed by the pre-update last integrator
    always_comb begin
        comb_c[0] = int_q[N_STAGES-1];
        for (int i = 0; i < N_STAGES; i++) begin
            comb_c[i+1] = comb_c[i] - dly_q[i];
        end
    end

    cic_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .N_STAGES   (N_STAGES),
        .POS_LIM    ((2 ** DATA_FRAC) - 1),
        .NEG_LIM    (-(2 ** DATA_FRAC))
    ) u_round_sat (
        .acc_i (comb_c[N_STAGES]),
        .dec_i (dec_q),
        .dat_o (rs_dat),
        .ovf_o (rs_ovf),
        .unf_o (rs_unf)
    );

    always_comb begin
        int_d   = int_q;
        dly_d   = dly_q;
        phase_d = phase_q;
        dec_d   = dec_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (cfg_load) begin
            for (int i = 0; i < N_STAGES; i++) begin
                int_d[i] = '0;
                dly_d[i] = '0;
            end
            phase_d = '0;
            dec_d   = clamp_dec_sel(dec_sel, MAX_DEC_LOG2);
        end else if (run) begin
            // Integrators are pipelined: each stage adds its predecessor's registered value.
            // Wrap at ACC_WIDTH is harmless, the combs undo it exactly.
            int_d[0] = int_q[0] + in_ext;
            for (int i = 1; i < N_STAGES; i++) begin
                int_d[i] = int_q[i] + int_q[i-1];
            end
            if (dec_strobe) begin
                phase_d = '0;
                for (int i = 0; i < N_STAGES; i++) begin
                    dly_d[i] = comb_c[i];
                end
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end

        if (cfg_load) begin
            vld_d = 1'b0;
        end else if (bypass) begin
            out_d = cic_in;
            vld_d = valid_in;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (dec_strobe) begin
            out_d = rs_dat;
            vld_d = 1'b1;
            ovf_d = rs_ovf;
            unf_d = rs_unf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_STAGES; i++) begin
                int_q[i] <= '0;
                dly_q[i] <= '0;
            end
            phase_q <= '0;
            dec_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            int_q   <= int_d;
            dly_q   <= dly_d;
            phase_q <= phase_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign cic_out   = out_q;
    assign valid_out = vld_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
